data_mem_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the 32-word data memory of the multicycle datapath.

---
 rtl/data_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-requester (CPU, debug) sequencer for a single-port data memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is CPU priority with a starvation guard.
module data_mem_arbiter #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [31:0]              cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic                     cpu_done,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_err,
    input  logic                     dbg_req,
    input  logic                     dbg_we,
    input  logic [31:0]              dbg_addr,
    input  logic [DATA_W-1:0]        dbg_wdata,
    output logic                     dbg_done,
    output logic [DATA_W-1:0]        dbg_rdata,
    output logic                     dbg_err,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state, state_nx;
    logic                owner_dbg;
    logic                we_q;
    logic [31:0]         addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                any_req;
    logic                grant_dbg;
    logic                legal;
    logic [DATA_W-1:0]   rd;

    assign any_req = cpu_req || dbg_req;
    assign legal   = addr_q < 32'(DEPTH);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Whoever was granted last yields the next tie.
    logic rr_dbg_first;
    assign grant_dbg = dbg_req && (!cpu_req || rr_dbg_first);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_dbg_first <= 1'b0;
        else if (state == IDLE && any_req)
            rr_dbg_first <= !grant_dbg;
    end
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;
    assign grant_dbg = dbg_req && (!cpu_req || starve_cnt == CW'(STARVE_LIMIT));
    // Counts CPU grants that overtook a waiting debug request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (state == IDLE && any_req)
            starve_cnt <= grant_dbg ? '0 : dbg_req ? starve_cnt + 1'b1 : starve_cnt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_dbg <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner_dbg <= grant_dbg;
                we_q      <= grant_dbg ? dbg_we    : cpu_we;
                addr_q    <= grant_dbg ? dbg_addr  : cpu_addr;
                wdata_q   <= grant_dbg ? dbg_wdata : cpu_wdata;
            end
        end
    end

    always_comb begin
        state_nx  = IDLE;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        cpu_done  = 1'b0;
        cpu_rdata = '0;
        cpu_err   = 1'b0;
        dbg_done  = 1'b0;
        dbg_rdata = '0;
        dbg_err   = 1'b0;
        rd        = (legal && !we_q) ? mem_rdata : '0;
        busy      = state != IDLE;
        case (state)
            IDLE:    state_nx = any_req ? ACCESS : IDLE;
            ACCESS: begin
                state_nx = RESP;
                if (legal) begin
                    mem_addr  = addr_q[AW-1:0];
                    mem_wdata = we_q ? wdata_q : '0;
                    mem_we    = we_q;
                    mem_re    = !we_q;
                end
            end
            RESP: begin
                state_nx = IDLE;
                if (owner_dbg) begin
                    dbg_done  = 1'b1;
                    dbg_rdata = rd;
                    dbg_err   = !legal;
                end else begin
                    cpu_done  = 1'b1;
                    cpu_rdata = rd;
                    cpu_err   = !legal;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench for data_mem_arbiter with a behavioural 32-word memory.
module tb_data_mem_arbiter;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
    logic        cpu_done, cpu_err, dbg_done, dbg_err, mem_we, mem_re, busy;
    logic [31:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic [4:0]  mem_addr;

    logic [31:0] mem [32];
    logic        mem_init = 1;
    logic [31:0] rdq = 0;
    int          n_strobe = 0;
    int          total = 0;
    int          bad = 0;
    logic        acc_we, acc_re;
    logic [4:0]  acc_addr;
    logic [31:0] acc_wdata;

    typedef struct packed {
        logic        who;
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_done(dbg_done), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    assign mem_rdata = rdq;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) rdq <= mem[mem_addr];
            if (mem_we || mem_re) n_strobe <= n_strobe + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (cpu_done || dbg_done)) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'({cpu_done, dbg_done}), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("owner", 64'(dbg_done), 64'(e.who));
                chk("both_done", 64'(cpu_done & dbg_done), 64'd0);
                chk("rdata", 64'(e.who ? dbg_rdata : cpu_rdata), 64'(e.rd));
                chk("err", 64'(e.who ? dbg_err : cpu_err), 64'(e.err));
                chk("other_quiet", 64'(e.who ? {cpu_rdata, cpu_err} : {dbg_rdata, dbg_err}), 64'd0);
            end
        end
    end

    task automatic op(input logic who, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   lat = 0;
        logic b0 = 1'b1, b1 = 1'b0;
        e.who = who; e.rd = exp_rd; e.err = exp_err;
        q.push_back(e);
        if (who) begin
            dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) b0 = busy;
            if (i == 2) begin
                b1 = busy; acc_we = mem_we; acc_re = mem_re; acc_addr = mem_addr; acc_wdata = mem_wdata;
            end
            if (who ? dbg_done : cpu_done) begin
                lat = i;
                break;
            end
        end
        chk("latency", 64'(lat), 64'd3);
        chk("busy_idle", 64'(b0), 64'd0);
        chk("busy_access", 64'(b1), 64'd1);
        @(posedge clk);
        #1;
        cpu_req = 0;
        dbg_req = 0;
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int s0;
        repeat (2) @(posedge clk);
        mem_init = 0;
        #2 rst_n = 1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'({cpu_done, dbg_done, cpu_err, dbg_err}), 64'd0);
        chk("rst_strobe", 64'({mem_we, mem_re, mem_addr}), 64'd0);
        chk("rst_rdata", 64'({cpu_rdata, dbg_rdata}), 64'd0);
        @(posedge clk);
        #1;

        op(0, 1, 5, 32'hDEAD_BEEF, 0, 0);
        chk("st_we", 64'({acc_we, acc_re}), 64'b10);
        chk("st_addr", 64'(acc_addr), 64'd5);
        chk("st_wdata", 64'(acc_wdata), 64'hDEAD_BEEF);
        op(0, 0, 5, 0, 32'hDEAD_BEEF, 0);
        chk("ld_re", 64'({acc_we, acc_re}), 64'b01);

        s0 = n_strobe;
        op(1, 0, 40, 0, 0, 1);
        chk("oor_nostrobe", 64'({acc_we, acc_re}), 64'd0);
        op(0, 0, 32, 0, 0, 1);
        op(0, 1, 32'h8000_0005, 32'h1111_1111, 0, 1);
        chk("oor_strobe_cnt", 64'(n_strobe - s0), 64'd0);
        op(0, 0, 5, 0, 32'hDEAD_BEEF, 0);
        op(1, 1, 10, 32'hCAFE_F00D, 0, 0);
        op(0, 0, 10, 0, 32'hCAFE_F00D, 0);

        op(0, 0, 0, 0, 32'h1000_0000, 0);
        op(0, 0, 31, 0, 32'h1000_001F, 0);
        chk("addr31", 64'(acc_addr), 64'd31);

        cpu_req = 1; cpu_we = 1; cpu_addr = 7; cpu_wdata = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_we", 64'(mem_we), 64'd1);
        #1 rst_n = 0;
        cpu_req = 0;
        #1;
        chk("rst_mid_we", 64'(mem_we), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        chk("rst_no_done", 64'({cpu_done, dbg_done}), 64'd0);
        #2 rst_n = 1;
        repeat (3) @(negedge clk);
        chk("after_rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        op(0, 0, 7, 0, 32'h1000_0007, 0);

        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            exp_t e;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            e.who = (i % 2) == 1;
`else
            e.who = (i % 5) == 4;
`endif
            e.rd = e.who ? 32'h1000_0002 : 32'h1000_0001;
            e.err = 0;
            q.push_back(e);
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 1;
        dbg_req = 1; dbg_we = 0; dbg_addr = 2;
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            if (cpu_done || dbg_done) n++;
        end
        chk("grant_count", 64'(n), 64'd10);
        @(posedge clk);
        #1;
        cpu_req = 0;
        dbg_req = 0;
        repeat (4) @(negedge clk);
        chk("sb_leftover", 64'(q.size()), 64'd0);
        q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
